// File: rtl/alu_mdu_seq_pkg.sv
// Shared op codes, FSM states and op-class helpers for the multi-cycle execute unit.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'h00, OP_SUB   = 5'h01, OP_SLT  = 5'h02, OP_SLTU = 5'h03,
        OP_XOR    = 5'h04, OP_OR    = 5'h05, OP_AND  = 5'h06, OP_SLL  = 5'h07,
        OP_SRL    = 5'h08, OP_SRA   = 5'h09, OP_LUI  = 5'h0A,
        OP_MUL    = 5'h10, OP_MULH  = 5'h11, OP_MULHSU = 5'h12, OP_MULHU = 5'h13,
        OP_DIV    = 5'h14, OP_DIVU  = 5'h15, OP_REM  = 5'h16, OP_REMU = 5'h17
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    function automatic logic is_muldiv(logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

    function automatic logic is_div(logic [4:0] op);
        return op[4:2] == 3'b101;
    endfunction

    function automatic logic is_signed_a(logic [4:0] op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(logic [4:0] op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/alu_mdu_seq_if.sv
// Request/response handshake bundle between the decoder (master) and the execute unit (slave).
interface alu_mdu_seq_if #(parameter int XLEN = 32);
    logic            i_flush;
    logic            i_valid;
    logic            o_ready;
    logic [4:0]      i_alu_op;
    logic [XLEN-1:0] i_operand_a;
    logic [XLEN-1:0] i_operand_b;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_alu_data;

    modport master (
        output i_flush, i_valid, i_alu_op, i_operand_a, i_operand_b, i_ready,
        input  o_ready, o_valid, o_alu_data
    );

    modport slave (
        input  i_flush, i_valid, i_alu_op, i_operand_a, i_operand_b, i_ready,
        output o_ready, o_valid, o_alu_data
    );
endinterface

// File: rtl/alu_mdu_seq_muldiv_iter.sv
// Radix-2 iterative engine on unsigned magnitudes: shift-add multiply or restoring divide.
// acc holds {hi, lo}: {product_hi, multiplier} while multiplying, {remainder, quotient} while dividing.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_start,
    input  logic              i_div,
    input  logic [XLEN-1:0]   i_lo,
    input  logic [XLEN-1:0]   i_m,
    output logic              o_busy,
    output logic              o_finish,
    output logic [2*XLEN-1:0] o_acc_next
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [2*XLEN-1:0] acc_q, acc_d, step_acc;
    logic [XLEN-1:0]   m_q, m_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d, div_q, div_d;
    logic [XLEN:0]     add_sum, trial;

    always_comb begin
        add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
        trial   = acc_q[2*XLEN-1:XLEN-1] - {1'b0, m_q};
        if (div_q) begin
            // trial subtract of the shifted partial remainder; keep it only if no borrow
            if (!trial[XLEN]) step_acc = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else              step_acc = {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
            step_acc = {add_sum, acc_q[XLEN-1:1]};
        end
    end

    assign o_finish   = busy_q && (cnt_q == CNT_W'(XLEN - 1));
    assign o_busy     = busy_q;
    assign o_acc_next = step_acc;

    always_comb begin
        acc_d  = acc_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        div_d  = div_q;
        if (i_flush) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (i_start) begin
            acc_d  = {{XLEN{1'b0}}, i_lo};
            m_d    = i_m;
            cnt_d  = '0;
            busy_d = 1'b1;
            div_d  = i_div;
        end else if (busy_q) begin
            acc_d = step_acc;
            cnt_d = cnt_q + 1'b1;
            if (o_finish) busy_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc_q  <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            div_q  <= div_d;
        end
    end
endmodule

// File: rtl/alu_mdu_seq.sv
// EX-stage integer unit: single-cycle registered base ALU plus iterative RV32M mul/div,
// with valid/ready on both sides so the core can stall behind long operations.
module alu_mdu_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    alu_mdu_seq_if.slave bus
);
    localparam int              SH_W    = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        op_q, op_d;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;

    logic [4:0]        req_op;
    logic [XLEN-1:0]   a, b, mag_a, mag_b, base_res, special_res, fix_res;
    logic              req_neg_a, req_neg_b, div_by_zero, div_ovf, slt;
    logic [XLEN:0]     sub_ext;
    logic [SH_W-1:0]   shamt;
    logic              start, finish, busy;
    logic [2*XLEN-1:0] acc_next, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    assign req_op      = bus.i_alu_op;
    assign a           = bus.i_operand_a;
    assign b           = bus.i_operand_b;
    assign shamt       = b[SH_W-1:0];
    assign req_neg_a   = is_signed_a(req_op) && a[XLEN-1];
    assign req_neg_b   = is_signed_b(req_op) && b[XLEN-1];
    assign mag_a       = req_neg_a ? -a : a;
    assign mag_b       = req_neg_b ? -b : b;
    assign div_by_zero = (b == '0);
    assign div_ovf     = is_signed_b(req_op) && (a == MIN_INT) && (&b);

    // signed compare: sign of the difference corrected by the subtract overflow
    assign sub_ext = {1'b0, a} - {1'b0, b};
    assign slt     = sub_ext[XLEN-1] ^ ((a[XLEN-1] ^ b[XLEN-1]) & (sub_ext[XLEN-1] ^ a[XLEN-1]));

    always_comb begin
        base_res = '0;
        case (op_e'(req_op))
            OP_ADD:  base_res = a + b;
            OP_SUB:  base_res = sub_ext[XLEN-1:0];
            OP_SLT:  base_res = XLEN'(slt);
            OP_SLTU: base_res = XLEN'(sub_ext[XLEN]);
            OP_XOR:  base_res = a ^ b;
            OP_OR:   base_res = a | b;
            OP_AND:  base_res = a & b;
            OP_SLL:  base_res = a << shamt;
            OP_SRL:  base_res = a >> shamt;
            OP_SRA:  base_res = XLEN'($signed(a) >>> shamt);
            OP_LUI:  base_res = b;
            default: base_res = '0;
        endcase
    end

    assign special_res = req_op[1] ? (div_by_zero ? a : '0)
                                   : (div_by_zero ? '1 : MIN_INT);

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_flush    (bus.i_flush),
        .i_start    (start),
        .i_div      (is_div(req_op)),
        .i_lo       (is_div(req_op) ? mag_a : mag_b),
        .i_m        (is_div(req_op) ? mag_b : mag_a),
        .o_busy     (busy),
        .o_finish   (finish),
        .o_acc_next (acc_next)
    );

    // sign fix-up is applied to the final step's value so the result lands on the DONE edge
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_next : acc_next;
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    assign rem_fix  = neg_a_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];

    always_comb begin
        case (op_e'(op_q))
            OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res = quo_fix;
            default:                      fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        start    = 1'b0;
        if (bus.i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (bus.i_valid) begin
                    op_d    = req_op;
                    neg_a_d = req_neg_a;
                    neg_b_d = req_neg_b;
                    if (!is_muldiv(req_op)) begin
                        result_d = base_res;
                        state_d  = S_DONE;
                    end else if (is_div(req_op) && (div_by_zero || div_ovf)) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        start   = 1'b1;
                        state_d = is_div(req_op) ? S_DIV : S_MUL;
                    end
                end
                S_MUL, S_DIV: begin
                    if (finish) begin
                        result_d = fix_res;
                        state_d  = S_DONE;
                    end else if (!busy) begin
                        state_d = S_IDLE;
                    end
                end
                S_DONE:  if (bus.i_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
        end
    end

    assign bus.o_ready    = (state_q == S_IDLE);
    assign bus.o_valid    = (state_q == S_DONE);
    assign bus.o_alu_data = result_q;
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Drives a 32-bit and a 16-bit instance in turn through directed vectors, stall/flush/reset
// sequences and random ops checked against an arithmetic reference model.
module tb_alu_mdu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, vld, rdy, flush;
    logic [4:0]  op;
    logic [31:0] a, b;
    int          sel, w;
    int          checks = 0, errors = 0;

    logic        ov, ordy;
    logic [31:0] od;

    always #5 clk = ~clk;

    alu_mdu_seq_if #(.XLEN(32)) bus32();
    alu_mdu_seq_if #(.XLEN(16)) bus16();

    assign bus32.i_valid     = vld && (sel == 0);
    assign bus32.i_flush     = flush && (sel == 0);
    assign bus32.i_alu_op    = op;
    assign bus32.i_operand_a = a;
    assign bus32.i_operand_b = b;
    assign bus32.i_ready     = rdy;
    assign bus16.i_valid     = vld && (sel == 1);
    assign bus16.i_flush     = flush && (sel == 1);
    assign bus16.i_alu_op    = op;
    assign bus16.i_operand_a = a[15:0];
    assign bus16.i_operand_b = b[15:0];
    assign bus16.i_ready     = rdy;

    assign ov   = (sel == 1) ? bus16.o_valid : bus32.o_valid;
    assign ordy = (sel == 1) ? bus16.o_ready : bus32.o_ready;
    assign od   = (sel == 1) ? {16'h0, bus16.o_alu_data} : bus32.o_alu_data;

    alu_mdu_seq #(.XLEN(32)) dut32 (.i_clk(clk), .i_reset(rst), .bus(bus32));
    alu_mdu_seq #(.XLEN(16)) dut16 (.i_clk(clk), .i_reset(rst), .bus(bus16));

    typedef struct {
        string      name;
        logic [4:0] op;
        logic [31:0] a32, b32, e32;
        logic [31:0] a16, b16, e16;
        bit         long_op;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (w=%0d) got %0h expected %0h", nm, w, act, exp);
        end
    endtask

    // Results follow RISC-V M rules evaluated with plain 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(logic [4:0] o, logic [31:0] ai, logic [31:0] bi, int wd);
        longint mask = (longint'(1) << wd) - 1;
        longint ua   = longint'(ai) & mask;
        longint ub   = longint'(bi) & mask;
        longint sa   = ((ua >> (wd - 1)) & 1) != 0 ? ua - (longint'(1) << wd) : ua;
        longint sb   = ((ub >> (wd - 1)) & 1) != 0 ? ub - (longint'(1) << wd) : ub;
        longint mn   = -(longint'(1) << (wd - 1));
        int     sh   = int'(ub & longint'(wd - 1));
        logic [63:0] pu;
        longint r;
        case (o)
            OP_ADD:    r = ua + ub;
            OP_SUB:    r = ua - ub;
            OP_SLT:    r = (sa < sb) ? 1 : 0;
            OP_SLTU:   r = (ua < ub) ? 1 : 0;
            OP_XOR:    r = ua ^ ub;
            OP_OR:     r = ua | ub;
            OP_AND:    r = ua & ub;
            OP_SLL:    r = ua << sh;
            OP_SRL:    r = ua >> sh;
            OP_SRA:    r = sa >>> sh;
            OP_LUI:    r = ub;
            OP_MUL:    r = sa * sb;
            OP_MULH:   r = (sa * sb) >>> wd;
            OP_MULHSU: r = (sa * ub) >>> wd;
            OP_MULHU:  begin pu = 64'(ua) * 64'(ub); r = longint'(pu >> wd); end
            OP_DIV:    r = (ub == 0) ? mask : (sa == mn && sb == -1) ? sa : sa / sb;
            OP_DIVU:   r = (ub == 0) ? mask : ua / ub;
            OP_REM:    r = (ub == 0) ? ua : (sa == mn && sb == -1) ? 0 : sa % sb;
            OP_REMU:   r = (ub == 0) ? ua : ua % ub;
            default:   r = 0;
        endcase
        return 32'(r & mask);
    endfunction

    function automatic int ref_lat(logic [4:0] o, logic [31:0] ai, logic [31:0] bi, int wd);
        longint mask = (longint'(1) << wd) - 1;
        longint ua = longint'(ai) & mask;
        longint ub = longint'(bi) & mask;
        bit     ovf = (o == OP_DIV || o == OP_REM) && ua == (longint'(1) << (wd - 1)) && ub == mask;
        if (!(o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU})) return 1;
        if ((o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) && (ub == 0 || ovf)) return 1;
        return wd + 1;
    endfunction

    function automatic logic [31:0] pick(int wd);
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h1 << (wd - 1);
            3:       return 32'($urandom_range(1, 9));
            default: return $urandom;
        endcase
    endfunction

    // Called at #1 after an edge with the unit idle; returns after hand-off when rdy=1.
    task automatic run_op(input string nm, input logic [4:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int lat);
        int n;
        chk({nm, " ready"}, 32'(ordy), 32'd1);
        op = o; a = x; b = y; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        n = 1;
        while (!ov && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'(lat));
        chk({nm, " data"}, od, exp);
        if (rdy) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [4:0]  rops[21] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND, OP_SLL,
                                  OP_SRL, OP_SRA, OP_LUI, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                  OP_DIV, OP_DIVU, OP_REM, OP_REMU, 5'h0B, 5'h1F};
        logic [31:0] d0, x, y;
        logic [4:0]  o;
        bit          seen;

        vt.push_back('{"ADD",    OP_ADD,    32'd7, 32'hFFFF_FFFD, 32'd4,        32'd7, 32'hFFFD, 32'd4,     1'b0});
        vt.push_back('{"SLT",    OP_SLT,    32'hFFFF_FFFF, 32'd1, 32'd1,        32'hFFFF, 32'd1, 32'd1,     1'b0});
        vt.push_back('{"SLTU",   OP_SLTU,   32'd1, 32'hFFFF_FFFF, 32'd1,        32'd1, 32'hFFFF, 32'd1,     1'b0});
        vt.push_back('{"SRA",    OP_SRA,    32'h8000_0000, 32'd4, 32'hF800_0000, 32'h8000, 32'd4, 32'hF800, 1'b0});
        vt.push_back('{"UNDEF",  5'h0B,     32'd5, 32'd6, 32'd0,                32'd5, 32'd6, 32'd0,        1'b0});
        vt.push_back('{"MULH",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h8000, 32'h8000, 32'h4000, 1'b1});
        vt.push_back('{"MULHSU", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 1'b1});
        vt.push_back('{"MULHU",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF, 32'hFFFF, 32'hFFFE, 1'b1});
        vt.push_back('{"DIV",    OP_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFF9, 32'd2, 32'hFFFD, 1'b1});
        vt.push_back('{"REM",    OP_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFF9, 32'd2, 32'hFFFF, 1'b1});
        vt.push_back('{"DIVU",   OP_DIVU,   32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 32'hFFFE, 32'd2, 32'h7FFF, 1'b1});
        vt.push_back('{"DIV0",   OP_DIV,    32'd5, 32'd0, 32'hFFFF_FFFF,        32'd5, 32'd0, 32'hFFFF,     1'b0});
        vt.push_back('{"REMU0",  OP_REMU,   32'd5, 32'd0, 32'd5,                32'd5, 32'd0, 32'd5,        1'b0});
        vt.push_back('{"DIVOVF", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000, 32'hFFFF, 32'h8000, 1'b0});

        rst = 1'b1; vld = 1'b0; rdy = 1'b1; flush = 1'b0; sel = 0; w = 32;
        op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s; w = (s == 0) ? 32 : 16; #1;
            chk("reset o_valid", 32'(ov), 32'd0);
            chk("reset o_ready", 32'(ordy), 32'd1);
            chk("reset data", od, 32'd0);
        end
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            sel = s; w = (s == 0) ? 32 : 16;
            @(posedge clk); #1;

            foreach (vt[i])
                run_op(vt[i].name, vt[i].op,
                       (s == 0) ? vt[i].a32 : vt[i].a16, (s == 0) ? vt[i].b32 : vt[i].b16,
                       (s == 0) ? vt[i].e32 : vt[i].e16, vt[i].long_op ? w + 1 : 1);

            // consumer stall on a finished divide, then back-to-back request
            rdy = 1'b0;
            run_op("hold DIV", OP_DIV, 32'hFFFF_FFF9, 32'd2, (s == 0) ? 32'hFFFF_FFFD : 32'hFFFD, w + 1);
            d0 = od;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                chk("hold o_valid", 32'(ov), 32'd1);
                chk("hold data", od, d0);
                chk("hold o_ready", 32'(ordy), 32'd0);
            end
            rdy = 1'b1;
            @(posedge clk); #1;
            chk("release o_ready", 32'(ordy), 32'd1);
            chk("release o_valid", 32'(ov), 32'd0);
            run_op("b2b ADD", OP_ADD, 32'd3, 32'd4, 32'd7, 1);

            // flush mid-multiply, with a competing request that must be ignored
            op = OP_MUL; a = 32'd1234; b = 32'd77; vld = 1'b1;
            @(posedge clk); #1;
            vld = 1'b0;
            repeat (9) begin @(posedge clk); #1; end
            flush = 1'b1; vld = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1;
            @(posedge clk); #1;
            flush = 1'b0; vld = 1'b0;
            chk("flush o_ready", 32'(ordy), 32'd1);
            chk("flush o_valid", 32'(ov), 32'd0);
            seen = 1'b0;
            repeat (w + 5) begin
                @(posedge clk); #1;
                if (ov) seen = 1'b1;
            end
            chk("flush no result", 32'(seen), 32'd0);

            // asynchronous reset in the middle of a divide
            op = OP_DIVU; a = 32'd1000; b = 32'd7; vld = 1'b1;
            @(posedge clk); #1;
            vld = 1'b0;
            repeat (4) begin @(posedge clk); #1; end
            #2 rst = 1'b1;
            #1;
            chk("areset o_valid", 32'(ov), 32'd0);
            chk("areset o_ready", 32'(ordy), 32'd1);
            chk("areset data", od, 32'd0);
            #2 rst = 1'b0;
            seen = 1'b0;
            repeat (w + 5) begin
                @(posedge clk); #1;
                if (ov || !ordy) seen = 1'b1;
            end
            chk("areset stays idle", 32'(seen), 32'd0);

            for (int i = 0; i < 120; i++) begin
                o = rops[$urandom_range(0, 20)];
                x = pick(w);
                y = pick(w);
                run_op("random", o, x, y, ref_model(o, x, y, w), ref_lat(o, x, y, w));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
